ripple_count_monitor: RTL and testbench

RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

---
 rtl/ripple_count_monitor_pkg.sv | 23 ++
 rtl/ripple_count_monitor_sync_ff_bus.sv | 30 +++
 rtl/ripple_count_monitor.sv | 116 +++++++++++
 tb/tb_ripple_count_monitor.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_count_monitor_pkg.sv
// Shared types and constants for the ripple counter monitor.
package ripple_count_monitor_pkg;

  // Default width of the accumulated event total.
  localparam int TOTAL_W_DEFAULT = 12;

  // Width of the upstream ripple counter being observed.
  localparam int UP_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    ALERT = 2'd2
  } state_t;

  // Forward distance from old_v to new_v on a counter that wraps at 2^UP_W.
  // The subtraction wraps naturally in UP_W bits, so 15 -> 0 yields 1.
  function automatic logic [UP_W-1:0] mod_delta(input logic [UP_W-1:0] new_v,
                                                input logic [UP_W-1:0] old_v);
    return new_v - old_v;
  endfunction

endpackage

// File: rtl/ripple_count_monitor_sync_ff_bus.sv
// Per-bit flop chain bringing an asynchronous bus into the clk domain.
module sync_ff_bus
  import ripple_count_monitor_pkg::*;
#(
  parameter int WIDTH = UP_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift the raw bus through DEPTH flops; every stage clears on reset.
  // NOTE: every synchronizer stage is reset so no stale pre-reset value can
  // leak out as a bogus count once reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/ripple_count_monitor.sv
// Watches an asynchronous 4-bit ripple counter, accumulates its advance into
// a saturating total and raises an alert once the total reaches a threshold.
module ripple_count_monitor
  import ripple_count_monitor_pkg::*;
#(
  parameter int TOTAL_W     = TOTAL_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [UP_W-1:0]    a_in,
  input  logic               enable,
  input  logic [TOTAL_W-1:0] threshold,
  input  logic               ack,
  output logic [TOTAL_W-1:0] total,
  output logic               valid,
  output logic               overflow,
  output logic [UP_W-1:0]    sample
);

  // A single flop is not a synchronizer, so shallower requests are raised to 2.
  localparam int DEPTH = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [UP_W-1:0]  sync_val;
  logic [UP_W-1:0]  filt_q;
  logic             accept;
  logic [UP_W-1:0]  delta;
  logic [UP_W-1:0]  add;
  logic [TOTAL_W:0] sum;
  logic             ack_take;
  state_t           state;
  state_t           state_next;

  sync_ff_bus #(
    .WIDTH (UP_W),
    .DEPTH (DEPTH)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (a_in),
    .q     (sync_val)
  );

  // Settle filter and delta: a synchronized value counts only once it has
  // been seen on two consecutive cycles, which hides mid-ripple codes.
  // NOTE: every signal driven here gets a value on every path, which is what
  // keeps combinational blocks from inferring latches.
  always_comb begin
    accept = (sync_val == filt_q);
    delta  = accept ? mod_delta(sync_val, sample) : '0;
    add    = enable ? delta : '0;
    sum    = {1'b0, total} + (TOTAL_W + 1)'(add);
  end

  // Next-state logic; an acknowledge only means something while alerting.
  always_comb begin
    state_next = state;
    ack_take   = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_next = TRACK;
      end
      TRACK: begin
        if (total >= threshold) state_next = ALERT;
        else if (!enable)       state_next = IDLE;
      end
      ALERT: begin
        if (ack) begin
          ack_take   = 1'b1;
          state_next = enable ? TRACK : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Filter history and last accepted upstream value; the baseline follows
  // the upstream counter even while accumulation is disabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= '0;
      sample <= '0;
    end else begin
      filt_q <= sync_val;
      if (accept) sample <= sync_val;
    end
  end

  // Saturating accumulator; an acknowledge restarts it from this cycle's delta.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total    <= '0;
      overflow <= 1'b0;
    end else if (ack_take) begin
      total    <= TOTAL_W'(add);
      overflow <= 1'b0;
    end else if (sum[TOTAL_W]) begin
      total    <= '1;
      overflow <= 1'b1;
    end else begin
      total    <= sum[TOTAL_W-1:0];
    end
  end

  // Alert is purely a decode of the state, so reset drops it at once.
  assign valid = (state == ALERT);

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench: directed cases for the boundary behaviour, then a
// randomized run compared against an event-level model of the monitor.
module tb_ripple_count_monitor;

  localparam int TW    = 12;
  localparam int TMAX  = (1 << TW) - 1;
  localparam int STEP  = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    a_in;
  logic          enable;
  logic [TW-1:0] threshold;
  logic          ack;
  logic [TW-1:0] total;
  logic          valid;
  logic          overflow;
  logic [3:0]    sample;

  logic [3:0]    a_in4;
  logic          enable4;
  logic [3:0]    threshold4;
  logic          ack4;
  logic [3:0]    total4;
  logic          valid4;
  logic          overflow4;
  logic [3:0]    sample4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ripple_count_monitor #(.TOTAL_W(TW), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in),
    .enable    (enable),
    .threshold (threshold),
    .ack       (ack),
    .total     (total),
    .valid     (valid),
    .overflow  (overflow),
    .sample    (sample)
  );

  ripple_count_monitor #(.TOTAL_W(4), .SYNC_STAGES(2)) dut4 (
    .clk       (clk),
    .reset     (reset),
    .a_in      (a_in4),
    .enable    (enable4),
    .threshold (threshold4),
    .ack       (ack4),
    .total     (total4),
    .valid     (valid4),
    .overflow  (overflow4),
    .sample    (sample4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_in = '0; enable = 1'b0; threshold = '1; ack = 1'b0;
    a_in4 = '0; enable4 = 1'b0; threshold4 = '1; ack4 = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic step(input logic [3:0] v);
    a_in = v;
    tick(STEP);
  endtask

  int exp_total;
  int t_cyc, v_cyc;

  // Random-phase model state
  int m_total, m_ovf, m_valid, m_thr, events, sum_v;
  logic [3:0] m_a;
  bit en, do_ack;

  initial begin
    do_reset();
    check("reset_total", total, 0);
    check("reset_valid", valid, 0);
    check("reset_overflow", overflow, 0);
    check("reset_sample", sample, 0);

    // Plain counting 0..5
    enable = 1'b1; threshold = 10;
    for (int v = 1; v <= 5; v++) step(4'(v));
    check("count5_total", total, 5);
    check("count5_valid", valid, 0);
    check("count5_sample", sample, 5);

    // Wrap 14,15,0,1: each step adds exactly one
    threshold = 100;
    step(4'd14);
    exp_total = 14;
    check("pre_wrap_total", total, exp_total);
    step(4'd15); exp_total++; check("wrap_15", total, exp_total);
    step(4'd0);  exp_total++; check("wrap_0", total, exp_total);
    step(4'd1);  exp_total++; check("wrap_1", total, exp_total);
    check("wrap_overflow", overflow, 0);

    // Glitch 3 -> 7 (one cycle) -> 4: only 4 is accepted
    step(4'd3); exp_total += 2;
    check("glitch_base", total, exp_total);
    a_in = 4'd7; tick(1);
    a_in = 4'd4; tick(STEP);
    exp_total += 1;
    check("glitch_total", total, exp_total);
    check("glitch_sample", sample, 4);

    // Alert latency at threshold 4
    do_reset();
    enable = 1'b1; threshold = 4;
    for (int v = 1; v <= 3; v++) step(4'(v));
    check("thr4_pre_valid", valid, 0);
    a_in = 4'd4;
    t_cyc = -1; v_cyc = -1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (t_cyc < 0 && total == 4) t_cyc = c;
      if (v_cyc < 0 && valid) v_cyc = c;
    end
    check("total_latency", t_cyc, 4);
    check("valid_latency", v_cyc, 5);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("ack_total", total, 0);
    check("ack_valid", valid, 0);

    // Ack on the same edge as an accepted change keeps that delta
    step(4'd9);
    check("realert_valid", valid, 1);
    a_in = 4'd11;
    tick(3);
    ack = 1'b1; tick(1); ack = 1'b0;
    check("ack_delta_total", total, 2);
    check("ack_delta_valid", valid, 0);

    // Ack outside ALERT is ignored
    ack = 1'b1; tick(1); ack = 1'b0;
    check("stray_ack_total", total, 2);

    // Threshold 0 alerts on the next cycle
    threshold = 0; tick(1);
    check("thr0_valid", valid, 1);

    // Saturation on the 4-bit instance
    do_reset();
    enable4 = 1'b1; threshold4 = 4'd15;
    for (int i = 1; i <= 20; i++) begin
      a_in4 = 4'(i);
      tick(STEP);
      if (i == 15) begin
        check("sat_exact_total", total4, 15);
        check("sat_exact_overflow", overflow4, 0);
      end
    end
    check("sat_total", total4, 15);
    check("sat_overflow", overflow4, 1);
    check("sat_valid", valid4, 1);
    ack4 = 1'b1; tick(1); ack4 = 1'b0;
    check("sat_ack_total", total4, 0);
    check("sat_ack_overflow", overflow4, 0);
    check("sat_ack_valid", valid4, 0);

    // Asynchronous reset in the middle of an alert
    do_reset();
    enable = 1'b1; threshold = 2;
    step(4'd3);
    check("pre_rst_valid", valid, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", valid, 0);
    check("async_rst_total", total, 0);
    check("async_rst_sample", sample, 0);
    a_in = 4'd6; enable = 1'b0; threshold = 0;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("post_rst_idle_valid", valid, 0);
    check("post_rst_disabled_total", total, 0);
    check("post_rst_sample", sample, 6);

    // Nonzero upstream value after reset counts from 0
    reset = 1'b1; a_in = 4'd9; enable = 1'b1; threshold = 100;
    tick(2);
    reset = 1'b0;
    tick(8);
    check("post_rst_delta_total", total, 9);

    // Randomized run against the event-level model
    do_reset();
    m_total = 0; m_ovf = 0; m_valid = 0; m_a = '0; m_thr = 0;
    for (int s = 0; s < 200; s++) begin
      events = $urandom_range(0, 15);
      do_ack = ($urandom_range(0, 3) == 0);
      if (s % 25 == 0) begin
        en = 1'b1;
        m_thr = $urandom_range(0, 200);
      end else begin
        en = ($urandom_range(0, 3) != 0);
      end
      m_a = m_a + 4'(events);
      enable = en; threshold = TW'(m_thr); a_in = m_a; ack = do_ack;
      tick(1);
      ack = 1'b0;
      tick(STEP - 1);

      if (do_ack && m_valid != 0) begin
        m_total = 0; m_ovf = 0; m_valid = 0;
      end
      if (en) begin
        sum_v = m_total + events;
        if (sum_v > TMAX) begin
          m_total = TMAX; m_ovf = 1;
        end else begin
          m_total = sum_v;
        end
        if (m_total >= m_thr) m_valid = 1;
      end

      check("rnd_total", total, m_total);
      check("rnd_valid", valid, m_valid);
      check("rnd_overflow", overflow, m_ovf);
      check("rnd_sample", sample, m_a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
